er_scheduler: RTL and testbench
===============================

ER_SCHEDULER -- requirements
Module: er_scheduler

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter FRAME_DIV, default 1, SHALL set the continuous-mode draw rate: one draw per FRAME_DIV due frames, legal range 1-255.
REQ-003 Parameter CLEAR_EN, default 1, SHALL select whether a canvas clear precedes each draw: 1 = clear then draw, 0 = draw only.
REQ-004 Parameter CNTW, default 16, SHALL set the width of frame_cnt and overrun_cnt.
REQ-005 The ports SHALL be as follows (name, direction, width, meaning):
- clk_sys  input  1  system clock
- rst_sys  input  1  asynchronous active-high reset
- frame_start  input  1  one-cycle pulse at frame start, already synchronous to clk_sys
- sched_en  input  1  level; scheduler enable
- mode_cont  input  1  1 = continuous, 0 = one-shot
- trig  input  1  one-cycle one-shot draw request
- clr_start  output  1  one-cycle pulse to the canvas clear engine
- clr_done  input  1  one-cycle pulse; clear finished
- er_start  output  1  one-cycle pulse to the Earthrise engine
- er_done  input  1  one-cycle pulse; drawing list finished
- busy  output  1  high in CLEAR or DRAW
- frame_cnt  output  CNTW  completed draws
- overrun_cnt  output  CNTW  skipped due frames

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, CLEAR, DRAW.
REQ-007 The divider SHALL behave as follows:
- While sched_en=0, div_cnt is held at 0.
- While sched_en=1, on each frame_start: if div_cnt==FRAME_DIV-1, the frame is "due" and div_cnt<=0; otherwise div_cnt increments.
REQ-008 A launch SHALL occur when the state is IDLE, sched_en=1 and frame_start=1, and either:
- mode_cont=1 and the frame is due; or
- mode_cont=0 and pending=1 (the divider is ignored in one-shot mode).
REQ-009 Launch SHALL go IDLE->CLEAR with clr_start=1 in the next cycle if CLEAR_EN=1, else IDLE->DRAW with er_start=1 in the next cycle; latency is frame_start at N -> pulse at N+1.
REQ-010 In CLEAR, clr_done at cycle M SHALL cause CLEAR->DRAW with er_start=1 at M+1.
REQ-011 In DRAW, er_done at cycle K SHALL cause DRAW->IDLE, with busy=0 and frame_cnt incremented at K+1.
REQ-012 clr_start and er_start SHALL each be exactly one cycle wide, with at most one of each per launch.
REQ-013 clr_done outside CLEAR and er_done outside DRAW SHALL be ignored.
REQ-014 Overrun handling SHALL be as follows:
- A frame that would have launched (per REQ-008, ignoring the IDLE condition) but arrives while the state is CLEAR or DRAW increments overrun_cnt.
- Overruns are not queued; no launch results.
REQ-015 Simultaneous events SHALL be decided on the registered state: er_done and frame_start in the same DRAW cycle is an overrun; the next launch needs a later frame_start.
REQ-016 trig SHALL set pending (one level, no further queueing) in any state when sched_en=1 and mode_cont=0; pending clears on launch.
REQ-017 sched_en falling during CLEAR or DRAW SHALL let the sequence complete, clear pending, and block new launches.
REQ-018 A change of mode_cont SHALL take effect at the next frame_start, and SHALL NOT abort an active sequence.
REQ-019 frame_cnt and overrun_cnt SHALL wrap from 2^CNTW-1 to 0 without saturating.

Reset
REQ-020 While rst_sys=1, asynchronously and independent of clk_sys, the block SHALL hold:
- state IDLE;
- div_cnt, pending, clr_start, er_start, busy, frame_cnt and overrun_cnt all 0.
REQ-021 Reset asserted mid-CLEAR or mid-DRAW SHALL abandon the sequence; done pulses arriving after reset release SHALL be ignored per REQ-013.

Verification
REQ-022 Bench scenarios:
- Basic sequence (FRAME_DIV=1, CLEAR_EN=1, continuous): frame_start@10 -> clr_start@11; clr_done@20 -> er_start@21; er_done@40 -> busy=0@41, frame_cnt=1.
- Divider (FRAME_DIV=3, continuous, prompt done pulses): 6 frame_start pulses -> launches only on pulses 3 and 6; frame_cnt=2, overrun_cnt=0.
- Overrun (FRAME_DIV=1): er_done withheld across 2 further frame_start pulses -> overrun_cnt=2, no extra er_start; then er_done -> frame_cnt=1.
- One-shot: trig@5, frame_start@30 -> launch@31; next frame_start with no trig -> no launch; trig during DRAW -> launch at first frame_start after IDLE.
- No clear (CLEAR_EN=0): frame_start@10 -> er_start@11; clr_start never asserted.
- Reset mid-DRAW: rst_sys pulse -> outputs 0 within the same cycle, counters 0; a later er_done produces no change.

Source files
------------

// File: rtl/er_scheduler.sv
// ---------------------------------------------------------------------------
// er_scheduler
//
// Frame-locked launcher for the Earthrise drawing engine. On a qualifying
// frame_start it optionally kicks the canvas clear engine, then the Earthrise
// engine, and waits for each engine's done pulse before returning to IDLE.
// Frames that would have launched while a sequence is still running are
// counted as overruns and dropped.
//
// Parameters
//   FRAME_DIV  continuous mode draws once every FRAME_DIV due frames (1..255)
//   CLEAR_EN   1 = clear canvas before each draw, 0 = draw only
//   CNTW       width of frame_cnt / overrun_cnt
//
// Ports
//   clk_sys      in   system clock
//   rst_sys      in   asynchronous active-high reset
//   frame_start  in   one-cycle pulse at frame start (clk_sys domain)
//   sched_en     in   scheduler enable (level)
//   mode_cont    in   1 = continuous, 0 = one-shot
//   trig         in   one-cycle one-shot draw request
//   clr_start    out  one-cycle pulse to the clear engine
//   clr_done     in   one-cycle pulse, clear finished
//   er_start     out  one-cycle pulse to the Earthrise engine
//   er_done      in   one-cycle pulse, drawing list finished
//   busy         out  high while clearing or drawing
//   frame_cnt    out  completed draws (wrapping)
//   overrun_cnt  out  skipped due frames (wrapping)
// ---------------------------------------------------------------------------
module er_scheduler #(
    parameter int FRAME_DIV = 1,
    parameter int CLEAR_EN  = 1,
    parameter int CNTW      = 16
) (
    input  logic            clk_sys,
    input  logic            rst_sys,
    input  logic            frame_start,
    input  logic            sched_en,
    input  logic            mode_cont,
    input  logic            trig,
    output logic            clr_start,
    input  logic            clr_done,
    output logic            er_start,
    input  logic            er_done,
    output logic            busy,
    output logic [CNTW-1:0] frame_cnt,
    output logic [CNTW-1:0] overrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAW  = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    state_t          state_q, state_d;
    logic [7:0]      div_cnt_q, div_cnt_d;
    logic            pending_q, pending_d;
    logic            clr_start_q, clr_start_d;
    logic            er_start_q, er_start_d;
    logic [CNTW-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNTW-1:0] overrun_cnt_q, overrun_cnt_d;

    logic frame_due;
    logic frame_go;
    logic launch;

    always_comb begin
        frame_due     = (div_cnt_q == DIV_LAST);
        // A frame that qualifies for a launch, regardless of the FSM state;
        // whether it launches or counts as an overrun is decided below.
        frame_go      = sched_en && frame_start && (mode_cont ? frame_due : pending_q);
        launch        = frame_go && (state_q == ST_IDLE);

        state_d       = state_q;
        clr_start_d   = 1'b0;
        er_start_d    = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        overrun_cnt_d = overrun_cnt_q;

        // Decided on the registered state: a frame landing in the same cycle
        // as er_done still sees DRAW and is an overrun.
        if (frame_go && (state_q != ST_IDLE)) begin
            overrun_cnt_d = overrun_cnt_q + CNTW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    if (CLEAR_EN != 0) begin
                        state_d     = ST_CLEAR;
                        clr_start_d = 1'b1;
                    end else begin
                        state_d    = ST_DRAW;
                        er_start_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (clr_done) begin
                    state_d    = ST_DRAW;
                    er_start_d = 1'b1;
                end
            end
            ST_DRAW: begin
                if (er_done) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = frame_cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The divider keeps counting in every mode and state so that the
        // continuous cadence stays locked to the frame stream.
        div_cnt_d = div_cnt_q;
        if (!sched_en) begin
            div_cnt_d = 8'd0;
        end else if (frame_start) begin
            div_cnt_d = frame_due ? 8'd0 : div_cnt_q + 8'd1;
        end

        // Single-level request latch; disabling the scheduler drops it.
        pending_d = pending_q;
        if (!sched_en) begin
            pending_d = 1'b0;
        end else begin
            if (launch) begin
                pending_d = 1'b0;
            end
            if (trig && !mode_cont) begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q       <= ST_IDLE;
            div_cnt_q     <= 8'd0;
            pending_q     <= 1'b0;
            clr_start_q   <= 1'b0;
            er_start_q    <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            pending_q     <= pending_d;
            clr_start_q   <= clr_start_d;
            er_start_q    <= er_start_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign clr_start   = clr_start_q;
    assign er_start    = er_start_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_er_scheduler.sv
// ---------------------------------------------------------------------------
// tb_er_scheduler
//
// Two scheduler instances share one stimulus stream:
//   u_dut0 : FRAME_DIV=3, CLEAR_EN=1
//   u_dut1 : FRAME_DIV=1, CLEAR_EN=0
// Both use a 4-bit counter width so the counters wrap during the run.
// The reference model treats a launch as a list of outstanding engine
// handshakes and predicts every output event for the following cycle into
// a scoreboard queue; a monitor on the falling clock edge consumes them.
// ---------------------------------------------------------------------------
module tb_er_scheduler;

    localparam int CW   = 4;
    localparam int WRAP = 1 << CW;

    localparam int K_CLR  = 0;
    localparam int K_OVR  = 1;
    localparam int K_ER   = 2;
    localparam int K_DONE = 3;
    localparam int K_BUSY = 4;

    localparam int H_CLR = 0;
    localparam int H_ER  = 1;

    typedef struct {
        int inst;
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst, fs, en, mc, trig, cd, ed;
    logic          cs [2];
    logic          es [2];
    logic          bz [2];
    logic [CW-1:0] fc [2];
    logic [CW-1:0] oc [2];

    er_scheduler #(.FRAME_DIV(3), .CLEAR_EN(1), .CNTW(CW)) u_dut0 (
        .clk_sys(clk), .rst_sys(rst), .frame_start(fs), .sched_en(en),
        .mode_cont(mc), .trig(trig), .clr_start(cs[0]), .clr_done(cd),
        .er_start(es[0]), .er_done(ed), .busy(bz[0]),
        .frame_cnt(fc[0]), .overrun_cnt(oc[0])
    );

    er_scheduler #(.FRAME_DIV(1), .CLEAR_EN(0), .CNTW(CW)) u_dut1 (
        .clk_sys(clk), .rst_sys(rst), .frame_start(fs), .sched_en(en),
        .mode_cont(mc), .trig(trig), .clr_start(cs[1]), .clr_done(cd),
        .er_start(es[1]), .er_done(ed), .busy(bz[1]),
        .frame_cnt(fc[1]), .overrun_cnt(oc[1])
    );

    always #5 clk = ~clk;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc_n    = 0;
    bit  mon_en   = 0;

    // reference model state
    int frames_en [2];
    bit pend      [2];
    int need_a    [2][2];
    int need_n    [2];
    int done_cnt  [2];
    int ovr_cnt   [2];

    function automatic int fd(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    function automatic bit ce(input int i);
        return (i == 0);
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_CLR:   return "clr_start";
            K_OVR:   return "overrun";
            K_ER:    return "er_start";
            K_DONE:  return "frame_done";
            default: return "busy";
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
    endtask

    task automatic push(input int i, input int k, input int v);
        ev_t e;
        e.inst = i; e.kind = k; e.cyc = cyc_n; e.val = v;
        sb.push_back(e);
    endtask

    function automatic int find_ev(input int i, input bit want_busy);
        for (int j = 0; j < sb.size(); j++)
            if (sb[j].inst == i && ((sb[j].kind == K_BUSY) == want_busy)) return j;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            frames_en[i] = 0; pend[i] = 0; need_n[i] = 0;
            done_cnt[i] = 0; ovr_cnt[i] = 0;
        end
        sb.delete();
    endtask

    // Predicts what each instance shows after the coming rising edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit in_flight, due, would, launch;
            in_flight = (need_n[i] > 0);
            due       = en && fs && ((frames_en[i] % fd(i)) == fd(i) - 1);
            would     = en && fs && (mc ? due : pend[i]);
            launch    = 0;
            if (would) begin
                if (!in_flight) begin
                    launch = 1;
                    if (ce(i)) begin
                        push(i, K_CLR, 0);
                        need_a[i][0] = H_CLR; need_a[i][1] = H_ER; need_n[i] = 2;
                    end else begin
                        push(i, K_ER, 0);
                        need_a[i][0] = H_ER; need_n[i] = 1;
                    end
                end else begin
                    ovr_cnt[i]++;
                    push(i, K_OVR, ovr_cnt[i] % WRAP);
                end
            end
            if (in_flight) begin
                if (need_a[i][0] == H_CLR && cd) begin
                    need_a[i][0] = need_a[i][1];
                    need_n[i]--;
                    push(i, K_ER, 0);
                end else if (need_a[i][0] == H_ER && ed) begin
                    need_n[i]--;
                    done_cnt[i]++;
                    push(i, K_DONE, done_cnt[i] % WRAP);
                end
            end
            if (!en) frames_en[i] = 0;
            else if (fs) frames_en[i]++;
            if (!en) pend[i] = 0;
            else begin
                if (launch) pend[i] = 0;
                if (trig && !mc) pend[i] = 1;
            end
            push(i, K_BUSY, (need_n[i] > 0) ? 1 : 0);
        end
    endtask

    task automatic cyc(input bit f, input bit t, input bit c, input bit e);
        fs = f; trig = t; cd = c; ed = e;
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
        cyc_n++;
        fs = 0; trig = 0; cd = 0; ed = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear
    // without waiting for a clock.
    task automatic do_reset();
        rst = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_clr_start%0d", i), int'(cs[i]), 0);
            chk($sformatf("rst_er_start%0d", i),  int'(es[i]), 0);
            chk($sformatf("rst_busy%0d", i),      int'(bz[i]), 0);
            chk($sformatf("rst_frame_cnt%0d", i), int'(fc[i]), 0);
            chk($sformatf("rst_overrun%0d", i),   int'(oc[i]), 0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 0;
        cyc_n++;
    endtask

    task automatic obs(input int i, input int k, input int v);
        int  idx;
        ev_t e;
        idx = find_ev(i, 0);
        n_checks++;
        if (idx < 0) begin
            $display("FAIL unexpected_%s%0d: got value %0d, expected no event (cycle %0d)",
                     kname(k), i, v, cyc_n);
            return;
        end
        e = sb[idx];
        sb.delete(idx);
        if (e.kind == k && e.cyc == cyc_n && e.val == v) n_pass++;
        else $display("FAIL event%0d: got %s=%0d at cycle %0d, expected %s=%0d at cycle %0d",
                      i, kname(k), v, cyc_n, kname(e.kind), e.val, e.cyc);
    endtask

    // Monitor: consumes predicted events on each falling edge.
    int prev_fc [2];
    int prev_oc [2];
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int i = 0; i < 2; i++) begin
                    if (rst) begin
                        prev_fc[i] = int'(fc[i]);
                        prev_oc[i] = int'(oc[i]);
                    end else begin
                        int  bi;
                        ev_t be;
                        bi = find_ev(i, 1);
                        if (bi >= 0) begin
                            be = sb[bi];
                            sb.delete(bi);
                            chk($sformatf("busy%0d", i), int'(bz[i]), be.val);
                        end
                        if (cs[i]) obs(i, K_CLR, 0);
                        if (int'(oc[i]) != prev_oc[i]) obs(i, K_OVR, int'(oc[i]));
                        if (es[i]) obs(i, K_ER, 0);
                        if (int'(fc[i]) != prev_fc[i]) obs(i, K_DONE, int'(fc[i]));
                        prev_fc[i] = int'(fc[i]);
                        prev_oc[i] = int'(oc[i]);
                        for (int j = sb.size() - 1; j >= 0; j--) begin
                            if (sb[j].inst == i && sb[j].kind != K_BUSY && sb[j].cyc <= cyc_n) begin
                                n_checks++;
                                $display("FAIL missing%0d: got no %s, expected %s=%0d at cycle %0d",
                                         i, kname(sb[j].kind), kname(sb[j].kind), sb[j].val, sb[j].cyc);
                                sb.delete(j);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int leftover;
        rst = 1; fs = 0; en = 0; mc = 1; trig = 0; cd = 0; ed = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("init_busy%0d", i),      int'(bz[i]), 0);
            chk($sformatf("init_frame_cnt%0d", i), int'(fc[i]), 0);
            chk($sformatf("init_overrun%0d", i),   int'(oc[i]), 0);
        end
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            prev_fc[i] = 0;
            prev_oc[i] = 0;
        end
        mon_en = 1;

        // basic continuous sequence
        en = 1; mc = 1;
        idle(10);
        cyc(1, 0, 0, 0);
        idle(9);
        cyc(0, 0, 1, 0);
        idle(19);
        cyc(0, 0, 0, 1);
        idle(5);

        // divider: restart it, then six frames with prompt done pulses
        en = 0; idle(1); en = 1;
        repeat (6) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 1, 0);
            cyc(0, 0, 0, 1);
            idle(2);
        end

        // overrun: draw held open across two more frames, then a frame
        // coinciding with er_done
        en = 0; idle(1); en = 1;
        repeat (2) begin cyc(1, 0, 0, 0); idle(3); end
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        idle(4);
        cyc(1, 0, 0, 0); idle(4);
        cyc(1, 0, 0, 0); idle(4);
        cyc(1, 0, 0, 1);
        idle(5);

        // one-shot
        mc = 0;
        cyc(0, 1, 0, 0);
        idle(10);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        idle(3);
        cyc(0, 1, 0, 0);
        idle(3);
        cyc(0, 0, 0, 1);
        idle(3);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        idle(3);
        cyc(1, 0, 0, 0);
        idle(5);

        // reset in the middle of a draw, then stray done pulses
        mc = 1;
        en = 0; idle(1); en = 1;
        cyc(1, 0, 0, 0); idle(2);
        cyc(1, 0, 0, 0); idle(2);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        idle(2);
        do_reset();
        idle(2);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 1);
        idle(3);

        // randomized traffic with mode/enable changes and one more reset
        for (int n = 0; n < 3000; n++) begin
            bit f, t, c, e;
            if ($urandom_range(149) == 0) en = ~en;
            if ($urandom_range(119) == 0) mc = ~mc;
            f = ($urandom_range(4) == 0);
            t = !f && ($urandom_range(7) == 0);
            c = ($urandom_range(5) == 0);
            e = ($urandom_range(6) == 0);
            if (n == 1500) do_reset();
            cyc(f, t, c, e);
        end
        idle(5);

        leftover = 0;
        foreach (sb[j]) if (sb[j].kind != K_BUSY) leftover++;
        chk("scoreboard_drained", leftover, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
